// File: rtl/fetch_queue_pkg.sv
// Shared constants and the stored entry type for the IF-to-ID fetch queue.
package fetch_queue_pkg;

  localparam int          FQ_DEPTH     = 4;
  localparam logic [31:0] FQ_NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-queue handshake: the IF/ID side drives as master, the queue is the slave.
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int PTR_W = $clog2(FQ_DEPTH)
);

  logic             in_valid;
  logic [31:0]      in_pc;
  logic [31:0]      in_instr;
  logic             full;
  logic             almost_full;
  logic             flush;
  logic             out_ready;
  logic             out_valid;
  logic [31:0]      out_pc;
  logic [31:0]      out_instr;
  logic [PTR_W:0]   count;

  modport master (
    output in_valid, in_pc, in_instr, flush, out_ready,
    input  full, almost_full, out_valid, out_pc, out_instr, count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, flush, out_ready,
    output full, almost_full, out_valid, out_pc, out_instr, count
  );

endinterface

// File: rtl/fetch_queue.sv
// Circular {PC, instruction} buffer between IF and ID; full stalls IF, flush
// discards every queued instruction on a redirect.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH     = FQ_DEPTH,
  parameter int          PTR_W     = $clog2(DEPTH),
  parameter logic [31:0] NOP_INSTR = FQ_NOP_INSTR
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.slave  bus
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   AF_CNT   = (PTR_W+1)'(DEPTH - 1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = (PTR_W)'(1);

  fq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   cnt;

  logic      push;
  logic      pop;
  logic      empty;
  fq_entry_t head;

  // full comes from registered cnt only, so ID readiness never reaches the IF stall.
  assign empty = (cnt == '0);
  assign push  = bus.in_valid && (cnt != FULL_CNT);
  assign pop   = bus.out_ready && !empty;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values,
    // so pointer and count updates in this block never see each other's new value.
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      // NOTE: the storage is cleared on reset so a released queue can never expose
      // stale words; this forces flops rather than a RAM macro, fine at this depth.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{pc: bus.in_pc, instr: bus.in_instr};
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  assign bus.full        = (cnt == FULL_CNT);
  assign bus.almost_full = (cnt >= AF_CNT);
  assign bus.count       = cnt;
  assign bus.out_valid   = !empty;
  assign bus.out_pc      = empty ? 32'h0 : head.pc;
  assign bus.out_instr   = empty ? NOP_INSTR : head.instr;

endmodule
